// File: rtl/wb_uart_bridge.sv
// Wishbone B4 classic slave exposing the uart RX/TX FIFOs as a 4-word register window
// (DATA, STATUS, CTRL, reserved) with a registered level interrupt.
module wb_uart_bridge #(
    parameter int ADDR_W     = 4,
    parameter bit BLOCKING   = 1'b1,
    parameter int TX_TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [ADDR_W-1:0] wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    input  logic [3:0]        wb_sel_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic              irq,
    output logic              rd_uart,
    output logic              wr_uart,
    output logic [7:0]        w_data,
    input  logic [7:0]        rd_data,
    input  logic              rx_empty,
    input  logic              tx_full
);
    typedef enum logic [1:0] {S_IDLE, S_RESP, S_WAIT_TX} state_t;

    localparam logic [1:0]  WORD_DATA   = 2'd0;
    localparam logic [1:0]  WORD_STATUS = 2'd1;
    localparam logic [1:0]  WORD_CTRL   = 2'd2;
    localparam logic [15:0] WAIT_LAST   = 16'(TX_TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_wait_cnt;
    logic [7:0]  r_drop_cnt;
    logic [7:0]  r_tx_byte;
    logic [1:0]  r_ctrl;
    logic [31:0] r_dat;
    logic        r_ack;
    logic        r_err;
    logic        r_irq;

    logic        w_req;
    logic [1:0]  w_word;
    logic        w_pop;
    logic        w_push;
    logic        w_resp_err;
    logic        w_cap;
    logic [31:0] w_cap_dat;
    logic        w_drop_inc;
    logic        w_drop_clr;
    logic        w_ctrl_we;
    logic        w_wait_start;
    logic        w_wait_inc;
    logic        w_unused;

    assign w_req    = wb_cyc_i & wb_stb_i;
    assign w_word   = wb_adr_i[3:2];
    assign w_unused = ^{wb_adr_i, wb_dat_i[31:8], wb_sel_i[3:1]};

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        w_next       = r_state;
        w_pop        = 1'b0;
        w_push       = 1'b0;
        w_resp_err   = 1'b0;
        w_cap        = 1'b0;
        w_cap_dat    = 32'h0;
        w_drop_inc   = 1'b0;
        w_drop_clr   = 1'b0;
        w_ctrl_we    = 1'b0;
        w_wait_start = 1'b0;
        w_wait_inc   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_next = S_RESP;
                    case (w_word)
                        WORD_DATA: begin
                            if (!wb_we_i) begin
                                w_cap = 1'b1;
                                if (!rx_empty) begin
                                    w_pop     = 1'b1;
                                    w_cap_dat = {23'h0, 1'b1, rd_data};
                                end
                            end else if (wb_sel_i[0]) begin
                                if (!tx_full) begin
                                    w_push = 1'b1;
                                end else if (BLOCKING) begin
                                    w_next       = S_WAIT_TX;
                                    w_wait_start = 1'b1;
                                end else begin
                                    w_drop_inc = 1'b1;
                                end
                            end
                        end
                        WORD_STATUS: begin
                            if (!wb_we_i) begin
                                w_cap     = 1'b1;
                                w_cap_dat = {16'h0, r_drop_cnt, 6'h0, tx_full, rx_empty};
                            end else begin
                                w_drop_clr = 1'b1;
                            end
                        end
                        WORD_CTRL: begin
                            if (!wb_we_i) begin
                                w_cap     = 1'b1;
                                w_cap_dat = {30'h0, r_ctrl};
                            end else begin
                                w_ctrl_we = wb_sel_i[0];
                            end
                        end
                        default: begin
                            // Reserved word: error response and a zeroed read bus either way.
                            w_cap      = 1'b1;
                            w_resp_err = 1'b1;
                        end
                    endcase
                end
            end
            S_RESP: w_next = S_IDLE;
            S_WAIT_TX: begin
                if (!wb_cyc_i) begin
                    w_next = S_IDLE;
                end else if (!tx_full) begin
                    w_push = 1'b1;
                    w_next = S_RESP;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_resp_err = 1'b1;
                    w_next     = S_RESP;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 16'h0;
            r_drop_cnt <= 8'h0;
            r_tx_byte  <= 8'h0;
            r_ctrl     <= 2'b00;
            r_dat      <= 32'h0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ack   <= (w_next == S_RESP) && !w_resp_err;
            r_err   <= (w_next == S_RESP) && w_resp_err;
            if (w_cap) begin
                r_dat <= w_cap_dat;
            end
            if (w_wait_start) begin
                r_wait_cnt <= 16'h0;
                r_tx_byte  <= wb_dat_i[7:0];
            end else if (w_wait_inc) begin
                r_wait_cnt <= r_wait_cnt + 16'd1;
            end
            if (w_drop_clr) begin
                r_drop_cnt <= 8'h0;
            end else if (w_drop_inc && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
            if (w_ctrl_we) begin
                r_ctrl <= wb_dat_i[1:0];
            end
            r_irq <= (r_ctrl[0] & ~rx_empty) | (r_ctrl[1] & ~tx_full);
        end
    end

    // FIFO strobes are combinational, so they are masked while reset aborts the access.
    assign rd_uart  = w_pop & ~reset;
    assign wr_uart  = w_push & ~reset;
    assign w_data   = wr_uart ? ((r_state == S_WAIT_TX) ? r_tx_byte : wb_dat_i[7:0]) : 8'h00;
    assign wb_dat_o = r_dat;
    assign wb_ack_o = r_ack;
    assign wb_err_o = r_err;
    assign irq      = r_irq;

endmodule
